xor_stream_cipher: RTL and testbench
====================================

// Module: xor_stream_cipher
// PURPOSE
//   Streaming successor of the one-shot wide XOR encryptor. Loads a runtime-length key
//   (1..KEY_WORDS words), then XORs a message stream word-by-word with the repeating key.
//   Valid/ready handshakes on the key, message and cipher ports. Optional key reuse across jobs.
//   XOR is symmetric, so the same block also decrypts. Sits between the UART/byte assembler and the TX path.
// PARAMETERS
//   DATA_W        8   width of one key/message/cipher word
//   KEY_WORDS     64  key storage depth (max key length, words)
//   MAX_MSG_WORDS 512 max message length per job (words)
// PORTS
//   iClk          in   1                          clock
//   iRst          in   1                          reset, asynchronous, active-high
//   iStart        in   1                          start job (sampled in IDLE only)
//   iReuse_key    in   1                          with iStart: skip key load, reuse stored key
//   iKey_len      in   $clog2(KEY_WORDS+1)        key length in words, latched on iStart
//   iMsg_len      in   $clog2(MAX_MSG_WORDS+1)    message length in words, latched on iStart
//   iKey_word     in   DATA_W                     key word
//   iKey_valid    in   1                          key word valid
//   oKey_ready    out  1                          key word accepted when valid&ready
//   iMsg_word     in   DATA_W                     plaintext word
//   iMsg_valid    in   1                          plaintext valid
//   oMsg_ready    out  1                          plaintext accepted when valid&ready
//   oCipher_word  out  DATA_W                     ciphertext word
//   oCipher_valid out  1                          ciphertext valid
//   iCipher_ready in   1                          downstream ready
//   oBusy         out  1                          high in any state other than IDLE
//   oDone         out  1                          1-cycle pulse at job end
//   oErr          out  1                          1-cycle pulse on rejected iStart
// BEHAVIOUR
//   Reset: every output is 0. FSM goes to IDLE. Counters are 0. key_loaded flag is 0. Key memory contents are don't-care.
//   FSM states: IDLE -> LOAD_KEY -> STREAM -> DONE -> IDLE.
//   IDLE: all readies are 0. iStart is rejected (oErr pulse, stay IDLE) if any of these hold:
//     - iKey_len==0 or iKey_len>KEY_WORDS
//     - iMsg_len==0 or iMsg_len>MAX_MSG_WORDS
//     - iReuse_key=1 and key_loaded=0
//   IDLE, valid iStart: latch both lengths. Go to STREAM if iReuse_key=1 (stored key length is kept); otherwise go to LOAD_KEY.
//   LOAD_KEY: oKey_ready=1. Each key handshake writes key_mem[kcnt] and increments kcnt.
//     On accepting word iKey_len-1: set key_loaded=1, clear kcnt, go to STREAM.
//   STREAM: oMsg_ready = (mcnt<msg_len) && (!oCipher_valid || iCipher_ready).
//     On a message handshake, the next edge registers:
//       - oCipher_word <= iMsg_word ^ key_mem[kidx]
//       - oCipher_valid <= 1
//       - mcnt increments
//       - kidx wraps to 0 after key_len-1, otherwise increments
//     Latency is 1 cycle. Throughput is 1 word/cycle with no bubbles when iCipher_ready is held high.
//     Output handshake with no new accept: oCipher_valid <= 0.
//     While oCipher_valid=1 and iCipher_ready=0: oCipher_word holds stable and no input is accepted.
//     Once mcnt==msg_len and the final output handshake completes: go to DONE.
//   DONE: oDone=1 for exactly one cycle, then IDLE. kidx resets to 0 for every job, so each message starts at key word 0.
//   iStart in any non-IDLE state is ignored (no oErr). iKey_valid outside LOAD_KEY and iMsg_valid outside STREAM are ignored.
//   Reset mid-job: async clear to the reset state. Any partial output is dropped. key_loaded=0.
// TESTING
//   1. Assert iRst mid-cycle -> all outputs 0 immediately. After release: oBusy=0, readies 0.
//   2. Key len 3 {A5,3C,FF}, msg len 7 {00..06}, ready held 1 -> cipher A5,3D,FD,A6,38,FA,A3 back-to-back.
//      oDone pulses on the cycle after the last output handshake.
//   3. Same job, iCipher_ready low 3 cycles after word 2 -> oCipher_word holds 3D, oMsg_ready=0.
//      Exactly 7 words out, none duplicated.
//   4. Follow-up iStart, iReuse_key=1, msg {A5,3C} -> no LOAD_KEY, cipher 00,00, oDone pulse.
//   5. iStart with iKey_len=0; then iMsg_len=MAX_MSG_WORDS+1; then iReuse_key=1 after reset -> oErr 1-cycle pulse each time.
//      State stays IDLE, oBusy=0.
//   6. iRst mid-STREAM after 4 words -> outputs 0. Next iStart with iReuse_key=1 -> oErr.
//      Full reload then gives correct cipher.

Source files
------------

// File: rtl/xor_stream_cipher_if.sv
// Handshake bundle for xor_stream_cipher: job control, key, message and cipher streams.
// The master side drives jobs and data; the slave side is the cipher block itself.
interface xor_stream_cipher_if #(
    parameter int DATA_W        = 8,
    parameter int KEY_WORDS     = 64,
    parameter int MAX_MSG_WORDS = 512
);
    localparam int KLW = $clog2(KEY_WORDS + 1);
    localparam int MLW = $clog2(MAX_MSG_WORDS + 1);

    logic              start;
    logic              reuse_key;
    logic [KLW-1:0]    key_len;
    logic [MLW-1:0]    msg_len;
    logic [DATA_W-1:0] key_word;
    logic              key_valid;
    logic              key_ready;
    logic [DATA_W-1:0] msg_word;
    logic              msg_valid;
    logic              msg_ready;
    logic [DATA_W-1:0] cipher_word;
    logic              cipher_valid;
    logic              cipher_ready;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, reuse_key, key_len, msg_len,
        output key_word, key_valid, msg_word, msg_valid, cipher_ready,
        input  key_ready, msg_ready, cipher_word, cipher_valid, busy, done, err
    );

    modport slave (
        input  start, reuse_key, key_len, msg_len,
        input  key_word, key_valid, msg_word, msg_valid, cipher_ready,
        output key_ready, msg_ready, cipher_word, cipher_valid, busy, done, err
    );
endinterface

// File: rtl/xor_stream_cipher.sv
// Streaming XOR cipher: loads a runtime-length key, then XORs each message word with the
// repeating key through a one-deep registered output stage. Encrypts and decrypts alike.
module xor_stream_cipher #(
    parameter int DATA_W        = 8,
    parameter int KEY_WORDS     = 64,
    parameter int MAX_MSG_WORDS = 512
) (
    input logic                clk_i,
    input logic                rst_i,
    xor_stream_cipher_if.slave bus
);
    // state      | meaning
    // S_IDLE     | waiting for start; lengths and key availability checked here
    // S_LOAD_KEY | accepting key words into key_mem
    // S_STREAM   | accepting message words, presenting cipher words
    // S_DONE     | one-cycle job-end pulse
    localparam int KLW = $clog2(KEY_WORDS + 1);
    localparam int MLW = $clog2(MAX_MSG_WORDS + 1);
    localparam int KIW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_KEY,
        S_STREAM,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [KLW-1:0]    key_len_q, key_len_d;
    logic [MLW-1:0]    msg_len_q, msg_len_d;
    logic [MLW-1:0]    mcnt_q, mcnt_d;
    logic [KIW-1:0]    kcnt_q, kcnt_d;
    logic [KIW-1:0]    kidx_q, kidx_d;
    logic              key_loaded_q, key_loaded_d;
    logic [DATA_W-1:0] cipher_word_q, cipher_word_d;
    logic              cipher_valid_q, cipher_valid_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] key_mem [KEY_WORDS];

    logic start_bad;
    logic key_fire;
    logic msg_ready;
    logic msg_fire;
    logic cipher_fire;

    assign start_bad = (bus.key_len == '0) || (bus.key_len > KLW'(KEY_WORDS)) ||
                       (bus.msg_len == '0) || (bus.msg_len > MLW'(MAX_MSG_WORDS)) ||
                       (bus.reuse_key && !key_loaded_q);

    assign key_fire    = (state_q == S_LOAD_KEY) && bus.key_valid;
    // A new word may enter only if the output slot is empty or drains this cycle.
    assign msg_ready   = (state_q == S_STREAM) && (mcnt_q < msg_len_q) &&
                         (!cipher_valid_q || bus.cipher_ready);
    assign msg_fire    = msg_ready && bus.msg_valid;
    assign cipher_fire = cipher_valid_q && bus.cipher_ready;

    always_ff @(posedge clk_i) begin
        if (key_fire) begin
            key_mem[kcnt_q] <= bus.key_word;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            key_len_q      <= '0;
            msg_len_q      <= '0;
            mcnt_q         <= '0;
            kcnt_q         <= '0;
            kidx_q         <= '0;
            key_loaded_q   <= 1'b0;
            cipher_word_q  <= '0;
            cipher_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_len_q      <= key_len_d;
            msg_len_q      <= msg_len_d;
            mcnt_q         <= mcnt_d;
            kcnt_q         <= kcnt_d;
            kidx_q         <= kidx_d;
            key_loaded_q   <= key_loaded_d;
            cipher_word_q  <= cipher_word_d;
            cipher_valid_q <= cipher_valid_d;
            err_q          <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        key_len_d      = key_len_q;
        msg_len_d      = msg_len_q;
        mcnt_d         = mcnt_q;
        kcnt_d         = kcnt_q;
        kidx_d         = kidx_q;
        key_loaded_d   = key_loaded_q;
        cipher_word_d  = cipher_word_q;
        cipher_valid_d = cipher_valid_q;
        err_d          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        msg_len_d = bus.msg_len;
                        mcnt_d    = '0;
                        kidx_d    = '0;
                        // Reuse keeps the key length that came with the stored key.
                        if (bus.reuse_key) begin
                            state_d = S_STREAM;
                        end else begin
                            key_len_d = bus.key_len;
                            kcnt_d    = '0;
                            state_d   = S_LOAD_KEY;
                        end
                    end
                end
            end
            S_LOAD_KEY: begin
                if (key_fire) begin
                    if (KLW'(kcnt_q) == key_len_q - KLW'(1)) begin
                        key_loaded_d = 1'b1;
                        kcnt_d       = '0;
                        state_d      = S_STREAM;
                    end else begin
                        kcnt_d = kcnt_q + KIW'(1);
                    end
                end
            end
            S_STREAM: begin
                if (msg_fire) begin
                    cipher_word_d  = bus.msg_word ^ key_mem[kidx_q];
                    cipher_valid_d = 1'b1;
                    mcnt_d         = mcnt_q + MLW'(1);
                    if (KLW'(kidx_q) == key_len_q - KLW'(1)) begin
                        kidx_d = '0;
                    end else begin
                        kidx_d = kidx_q + KIW'(1);
                    end
                end else if (cipher_fire) begin
                    cipher_valid_d = 1'b0;
                end
                if ((mcnt_q == msg_len_q) && cipher_fire) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                mcnt_d  = '0;
                kidx_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.key_ready    = (state_q == S_LOAD_KEY);
    assign bus.msg_ready    = msg_ready;
    assign bus.cipher_word  = cipher_word_q;
    assign bus.cipher_valid = cipher_valid_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.err          = err_q;
endmodule

// File: tb/tb_xor_stream_cipher.sv
// Bench for xor_stream_cipher: directed and randomized jobs checked against a reference
// model where cipher word i is message word i XOR key word (i mod key length).
module tb_xor_stream_cipher;
    localparam int DATA_W        = 8;
    localparam int KEY_WORDS     = 64;
    localparam int MAX_MSG_WORDS = 512;
    localparam int KLW           = $clog2(KEY_WORDS + 1);
    localparam int MLW           = $clog2(MAX_MSG_WORDS + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xor_stream_cipher_if #(
        .DATA_W(DATA_W), .KEY_WORDS(KEY_WORDS), .MAX_MSG_WORDS(MAX_MSG_WORDS)
    ) bus ();

    xor_stream_cipher #(
        .DATA_W(DATA_W), .KEY_WORDS(KEY_WORDS), .MAX_MSG_WORDS(MAX_MSG_WORDS)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] key_buf [KEY_WORDS];
    logic [7:0] msg_buf [MAX_MSG_WORDS];
    logic [7:0] mkey    [KEY_WORDS];
    int         mklen   = 0;
    bit         mloaded = 1'b0;
    logic [7:0] exp_q   [$];
    logic [7:0] got_log [$];
    int         cyc = 0;
    int         first_out_cyc, last_out_cyc, done_cyc;
    bit         aborted;
    logic [7:0] tbl2 [7];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({bus.key_ready, bus.msg_ready, bus.cipher_word, bus.cipher_valid,
                    bus.busy, bus.done, bus.err});
    endfunction

    task automatic idle_inputs();
        bus.start        = 1'b0;
        bus.reuse_key    = 1'b0;
        bus.key_len      = '0;
        bus.msg_len      = '0;
        bus.key_word     = '0;
        bus.key_valid    = 1'b0;
        bus.msg_word     = '0;
        bus.msg_valid    = 1'b0;
        bus.cipher_ready = 1'b0;
    endtask

    task automatic try_bad(input int klen, input int mlen, input bit reuse);
        @(negedge clk);
        idle_inputs();
        bus.start     = 1'b1;
        bus.reuse_key = reuse;
        bus.key_len   = KLW'(klen);
        bus.msg_len   = MLW'(mlen);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk("err_pulse", bus.err, 1);
        chk("err_stays_idle", bus.busy, 0);
        @(negedge clk);
        #1;
        chk("err_one_cycle", bus.err, 0);
        chk("err_idle_after", bus.busy, 0);
    endtask

    // mode 0: everything held valid/ready; 1: random handshakes and stray inputs;
    // 2: held, but downstream stalls 3 cycles while the second word is presented.
    task automatic run_job(input int klen, input int mlen, input bit reuse, input int mode,
                           input int stop_after, output bit ab);
        int ki = 0, mi = 0, outs = 0, stall = 0, kr_seen = 0, err_seen = 0, eklen;
        bit done_seen = 1'b0;
        ab = 1'b0;
        eklen = reuse ? mklen : klen;
        exp_q.delete();
        got_log.delete();
        @(negedge clk);
        cyc++;
        idle_inputs();
        bus.start     = 1'b1;
        bus.reuse_key = reuse;
        bus.key_len   = KLW'(klen);
        bus.msg_len   = MLW'(mlen);
        @(negedge clk);
        cyc++;
        bus.start = 1'b0;
        #1;
        chk("busy_after_start", bus.busy, 1);
        for (int c = 0; c < 20000 && !done_seen; c++) begin
            if (ki < klen && !reuse) begin
                bus.key_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.key_word  = key_buf[ki];
            end else begin
                bus.key_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.key_word  = 8'($urandom);
            end
            if (mi < mlen) begin
                bus.msg_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.msg_word  = msg_buf[mi];
            end else begin
                bus.msg_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.msg_word  = 8'($urandom);
            end
            bus.cipher_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mode == 2 && bus.cipher_valid && outs == 1 && stall < 3) begin
                bus.cipher_ready = 1'b0;
                stall++;
            end
            bus.start = (mode == 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
            #1;
            if (bus.key_ready) kr_seen++;
            if (bus.key_valid && bus.key_ready) begin
                mkey[ki] = bus.key_word;
                ki++;
                if (ki == klen) begin
                    mklen   = klen;
                    mloaded = 1'b1;
                end
            end
            if (bus.cipher_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else if (bus.cipher_ready) begin
                    chk("cipher_word", bus.cipher_word, exp_q.pop_front());
                    got_log.push_back(bus.cipher_word);
                    if (outs == 0) first_out_cyc = cyc;
                    last_out_cyc = cyc;
                    outs++;
                end else begin
                    chk("hold_word", bus.cipher_word, exp_q[0]);
                    chk("stall_msg_ready", bus.msg_ready, 0);
                end
            end
            if (bus.msg_valid && bus.msg_ready) begin
                exp_q.push_back(bus.msg_word ^ mkey[mi % eklen]);
                mi++;
            end
            if (bus.err) err_seen++;
            if (bus.done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            if (stop_after > 0 && outs >= stop_after) begin
                ab = 1'b1;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done_seen, 1);
        chk("out_count", outs, mlen);
        chk("no_err_in_job", err_seen, 0);
        if (reuse) chk("reuse_no_load", kr_seen, 0);
        idle_inputs();
        #1;
        chk("done_one_cycle", bus.done, 0);
        chk("idle_after_done", bus.busy, 0);
    endtask

    initial begin
        idle_inputs();
        tbl2[0] = 8'hA5; tbl2[1] = 8'h3D; tbl2[2] = 8'hFD; tbl2[3] = 8'hA6;
        tbl2[4] = 8'h38; tbl2[5] = 8'hFA; tbl2[6] = 8'hA3;

        #12;
        chk("reset_outputs", out_vec(), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_busy", bus.busy, 0);
        chk("post_reset_readies", {bus.key_ready, bus.msg_ready}, 0);

        try_bad(3, 7, 1);
        try_bad(0, 7, 0);
        try_bad(3, MAX_MSG_WORDS + 1, 0);
        try_bad(KEY_WORDS + 1, 7, 0);
        try_bad(3, 0, 0);

        key_buf[0] = 8'hA5; key_buf[1] = 8'h3C; key_buf[2] = 8'hFF;
        for (int i = 0; i < 7; i++) msg_buf[i] = 8'(i);
        run_job(3, 7, 0, 0, 0, aborted);
        chk("b2b_span", last_out_cyc - first_out_cyc, 6);
        chk("done_latency", done_cyc - last_out_cyc, 1);
        for (int i = 0; i < 7; i++) chk("known_cipher", got_log.size() > i ? got_log[i] : 8'hxx, tbl2[i]);

        run_job(3, 7, 0, 2, 0, aborted);
        for (int i = 0; i < 7; i++) chk("stall_cipher", got_log.size() > i ? got_log[i] : 8'hxx, tbl2[i]);

        msg_buf[0] = 8'hA5; msg_buf[1] = 8'h3C;
        run_job(5, 2, 1, 0, 0, aborted);
        chk("reuse_w0", got_log.size() > 0 ? got_log[0] : 8'hxx, 8'h00);
        chk("reuse_w1", got_log.size() > 1 ? got_log[1] : 8'hxx, 8'h00);

        for (int j = 0; j < 10; j++) begin
            int kl, ml;
            bit ru;
            kl = (j == 0) ? 1 : (j == 1) ? KEY_WORDS : int'($urandom_range(1, KEY_WORDS));
            ml = (j == 2) ? 1 : int'($urandom_range(1, 40));
            ru = mloaded && (j > 2) && ($urandom_range(0, 2) == 0);
            for (int k = 0; k < KEY_WORDS; k++) key_buf[k] = 8'($urandom);
            for (int m = 0; m < ml; m++) msg_buf[m] = 8'($urandom);
            run_job(kl, ml, ru, 1, 0, aborted);
        end

        for (int k = 0; k < KEY_WORDS; k++) key_buf[k] = 8'($urandom);
        for (int m = 0; m < MAX_MSG_WORDS; m++) msg_buf[m] = 8'($urandom);
        run_job(KEY_WORDS, MAX_MSG_WORDS, 0, 0, 0, aborted);

        for (int k = 0; k < 5; k++) key_buf[k] = 8'($urandom);
        for (int m = 0; m < 10; m++) msg_buf[m] = 8'($urandom);
        run_job(5, 10, 0, 0, 4, aborted);
        chk("abort_reached", aborted, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_stream_reset", out_vec(), 0);
        mloaded = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        try_bad(5, 10, 1);
        run_job(5, 10, 0, 1, 0, aborted);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
